// File: rtl/pingpong_line_ctrl_if.sv
// Pixel-in / FIFO-write / read-select bundle between the camera-side environment
// and the ping-pong line controller.
interface pingpong_line_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 11
);
  logic                  i_vsync;
  logic                  i_href;
  logic                  i_pixel_valid;
  logic [DATA_WIDTH-1:0] i_pixel_data;
  logic                  o_fifo1_wr_en;
  logic                  o_fifo2_wr_en;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  i_fifo_rd_en;
  logic                  o_fifo_choose;
  logic                  o_line_ready;
  logic [CNT_WIDTH-1:0]  o_line_len;
  logic                  o_line_done;
  logic                  o_overflow;
  logic                  o_rd_err;
  logic [11:0]           o_line_cnt;

  modport master (
    output i_vsync, i_href, i_pixel_valid, i_pixel_data, i_fifo_rd_en,
    input  o_fifo1_wr_en, o_fifo2_wr_en, o_wr_data, o_fifo_choose, o_line_ready,
    input  o_line_len, o_line_done, o_overflow, o_rd_err, o_line_cnt
  );

  modport slave (
    input  i_vsync, i_href, i_pixel_valid, i_pixel_data, i_fifo_rd_en,
    output o_fifo1_wr_en, o_fifo2_wr_en, o_wr_data, o_fifo_choose, o_line_ready,
    output o_line_len, o_line_done, o_overflow, o_rd_err, o_line_cnt
  );
endinterface

// File: rtl/pingpong_line_ctrl.sv
// Ping-pong write scheduler for two line FIFOs: one video line per buffer, read-side select and drain tracking.
// Optional per-frame committed-line counter enabled by defining PINGPONG_LINE_CNT_EN.
module pingpong_line_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_WIDTH  = 11
) (
  input logic                 clk,
  input logic                 rst_n,
  pingpong_line_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2, B_DRAINING = 2'd3} buf_st_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_FILL = 2'd2, W_DROP = 2'd3} wr_st_t;

  wr_st_t                r_wr_st, w_wr_st_nxt;
  buf_st_t               r_buf_st [2];
  buf_st_t               w_buf_st_nxt [2];
  logic [CNT_WIDTH-1:0]  r_len [2];
  logic [CNT_WIDTH-1:0]  w_len_nxt [2];
  logic [CNT_WIDTH-1:0]  r_rem [2];
  logic [CNT_WIDTH-1:0]  w_rem_nxt [2];
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_href_d, r_vsync_d;
  logic                  r_wr_sel, r_rd_sel, w_rd_sel_nxt;
  logic                  r_fifo1_wr_en, r_fifo2_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_line_ready, r_line_done, r_overflow, r_rd_err;
  logic [CNT_WIDTH-1:0]  r_line_len;

  logic w_href_rise, w_href_fall, w_vsync_rise, w_vsync_fall;
  logic w_start_fill, w_start_drop, w_pix_wr, w_trunc, w_commit, w_abandon;
  logic w_ready, w_rd_err;

  assign w_href_rise  = bus.i_href & ~r_href_d;
  assign w_href_fall  = ~bus.i_href & r_href_d;
  assign w_vsync_rise = bus.i_vsync & ~r_vsync_d;
  assign w_vsync_fall = ~bus.i_vsync & r_vsync_d;
  assign w_ready      = (r_buf_st[r_rd_sel] == B_FULL) || (r_buf_st[r_rd_sel] == B_DRAINING);

  // Write FSM state register and framing edge delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_st   <= W_IDLE;
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_wr_st   <= w_wr_st_nxt;
      r_href_d  <= bus.i_href;
      r_vsync_d <= bus.i_vsync;
    end
  end

  // Write FSM next state and per-cycle write-side events; vsync rise overrides everything.
  always_comb begin
    w_wr_st_nxt  = r_wr_st;
    w_start_fill = 1'b0;
    w_start_drop = 1'b0;
    w_pix_wr     = 1'b0;
    w_trunc      = 1'b0;
    w_commit     = 1'b0;
    w_abandon    = 1'b0;
    if (w_vsync_rise) begin
      w_wr_st_nxt = W_IDLE;
    end else begin
      case (r_wr_st)
        W_IDLE: begin
          if (w_vsync_fall) w_wr_st_nxt = W_WAIT;
          else              w_wr_st_nxt = W_IDLE;
        end
        W_WAIT: begin
          if (w_href_rise && !bus.i_vsync) begin
            // A buffer freed by a read this very cycle still reads as busy here.
            if (r_buf_st[r_wr_sel] == B_EMPTY) begin
              w_wr_st_nxt  = W_FILL;
              w_start_fill = 1'b1;
              w_pix_wr     = bus.i_pixel_valid;
            end else begin
              w_wr_st_nxt  = W_DROP;
              w_start_drop = 1'b1;
            end
          end else begin
            w_wr_st_nxt = W_WAIT;
          end
        end
        W_FILL: begin
          if (w_href_fall) begin
            w_wr_st_nxt = W_WAIT;
            if (r_cnt != '0) w_commit  = 1'b1;
            else             w_abandon = 1'b1;
          end else if (bus.i_href && bus.i_pixel_valid) begin
            if (r_cnt < DEPTH_C) w_pix_wr = 1'b1;
            else                 w_trunc  = 1'b1;
          end else begin
            w_wr_st_nxt = W_FILL;
          end
        end
        W_DROP: begin
          if (w_href_fall) w_wr_st_nxt = W_WAIT;
          else             w_wr_st_nxt = W_DROP;
        end
        default: w_wr_st_nxt = W_IDLE;
      endcase
    end
  end

  // Buffer bookkeeping: reads touch FULL/DRAINING, writes touch EMPTY/FILLING, so both can land together.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_buf_st_nxt[b] = r_buf_st[b];
      w_len_nxt[b]    = r_len[b];
      w_rem_nxt[b]    = r_rem[b];
    end
    w_rd_sel_nxt = r_rd_sel;
    w_rd_err     = 1'b0;
    if (bus.i_fifo_rd_en) begin
      if (w_ready) begin
        w_rem_nxt[r_rd_sel] = r_rem[r_rd_sel] - ONE_C;
        if (r_rem[r_rd_sel] == ONE_C) begin
          w_buf_st_nxt[r_rd_sel] = B_EMPTY;
          w_rd_sel_nxt           = ~r_rd_sel;
        end else begin
          w_buf_st_nxt[r_rd_sel] = B_DRAINING;
        end
      end else begin
        w_rd_err = 1'b1;
      end
    end else begin
      w_rd_err = 1'b0;
    end
    if (w_vsync_rise) begin
      for (int b = 0; b < 2; b++) begin
        if (r_buf_st[b] == B_FILLING) w_buf_st_nxt[b] = B_EMPTY;
        else                          w_buf_st_nxt[b] = w_buf_st_nxt[b];
      end
    end else if (w_start_fill) begin
      w_buf_st_nxt[r_wr_sel] = B_FILLING;
    end else if (w_commit) begin
      w_buf_st_nxt[r_wr_sel] = B_FULL;
      w_len_nxt[r_wr_sel]    = r_cnt;
      w_rem_nxt[r_wr_sel]    = r_cnt;
    end else if (w_abandon) begin
      w_buf_st_nxt[r_wr_sel] = B_EMPTY;
    end else begin
      w_rd_sel_nxt = w_rd_sel_nxt;
    end
  end

  // Buffer state, selects, pixel counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        r_buf_st[b] <= B_EMPTY;
        r_len[b]    <= '0;
        r_rem[b]    <= '0;
      end
      r_cnt         <= '0;
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_fifo1_wr_en <= 1'b0;
      r_fifo2_wr_en <= 1'b0;
      r_wr_data     <= '0;
      r_line_ready  <= 1'b0;
      r_line_len    <= '0;
      r_line_done   <= 1'b0;
      r_overflow    <= 1'b0;
      r_rd_err      <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        r_buf_st[b] <= w_buf_st_nxt[b];
        r_len[b]    <= w_len_nxt[b];
        r_rem[b]    <= w_rem_nxt[b];
      end
      if (w_start_fill)  r_cnt <= {{(CNT_WIDTH-1){1'b0}}, bus.i_pixel_valid};
      else if (w_pix_wr) r_cnt <= r_cnt + ONE_C;
      if (w_commit) r_wr_sel <= ~r_wr_sel;
      r_rd_sel      <= w_rd_sel_nxt;
      r_fifo1_wr_en <= w_pix_wr & ~r_wr_sel;
      r_fifo2_wr_en <= w_pix_wr & r_wr_sel;
      if (w_pix_wr) r_wr_data <= bus.i_pixel_data;
      // Ready/length are registered from next-state so they track the buffer registers with no lag.
      r_line_ready  <= (w_buf_st_nxt[w_rd_sel_nxt] == B_FULL) || (w_buf_st_nxt[w_rd_sel_nxt] == B_DRAINING);
      r_line_len    <= w_len_nxt[w_rd_sel_nxt];
      r_line_done   <= w_commit;
      r_overflow    <= r_overflow | w_start_drop | w_trunc;
      r_rd_err      <= r_rd_err | w_rd_err;
    end
  end

  assign bus.o_fifo1_wr_en = r_fifo1_wr_en;
  assign bus.o_fifo2_wr_en = r_fifo2_wr_en;
  assign bus.o_wr_data     = r_wr_data;
  assign bus.o_fifo_choose = r_rd_sel;
  assign bus.o_line_ready  = r_line_ready;
  assign bus.o_line_len    = r_line_len;
  assign bus.o_line_done   = r_line_done;
  assign bus.o_overflow    = r_overflow;
  assign bus.o_rd_err      = r_rd_err;

`ifdef PINGPONG_LINE_CNT_EN
  logic [11:0] r_line_cnt;

  // Committed-line counter, saturating, cleared at the start of vertical blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= 12'd0;
    end else if (w_vsync_rise) begin
      r_line_cnt <= 12'd0;
    end else if (w_commit && (r_line_cnt != 12'hFFF)) begin
      r_line_cnt <= r_line_cnt + 12'd1;
    end
  end

  assign bus.o_line_cnt = r_line_cnt;
`else
  assign bus.o_line_cnt = 12'd0;
`endif

endmodule

// File: tb/tb_pingpong_line_ctrl.sv
// Directed bench for pingpong_line_ctrl: vector table for the basic ping-pong flow plus
// hand sequences for mid-line reset, depth truncation and vsync abort.
module tb_pingpong_line_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pingpong_line_ctrl_if #(.DATA_WIDTH(16), .CNT_WIDTH(11)) bus ();

  pingpong_line_ctrl #(.DATA_WIDTH(16), .FIFO_DEPTH(1024), .CNT_WIDTH(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        vs, hr, pv;
    logic [15:0] pd;
    logic        rd;
    logic        wr1, wr2;
    logic [15:0] wd;
    logic        done, rdy;
    logic [10:0] len;
    logic        ch, ovf, err;
  } vec_t;

  vec_t tbl [26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {30'd0, bus.o_fifo1_wr_en, bus.o_fifo2_wr_en, bus.o_wr_data, bus.o_line_done,
            bus.o_line_ready, bus.o_line_len, bus.o_fifo_choose, bus.o_overflow, bus.o_rd_err};
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic pv, input logic [15:0] pd, input logic rd);
    bus.i_vsync       = vs;
    bus.i_href        = hr;
    bus.i_pixel_valid = pv;
    bus.i_pixel_data  = pd;
    bus.i_fifo_rd_en  = rd;
  endtask

  initial begin
    int n1, n2;
    logic [11:0] exp_cnt;
    checks   = 0;
    failures = 0;
`ifdef PINGPONG_LINE_CNT_EN
    exp_cnt = 12'd1;
`else
    exp_cnt = 12'd0;
`endif

    // vs hr pv pd rd | wr1 wr2 wd done rdy len ch ovf err
    tbl[0]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h0000,1'b0,1'b0,11'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,16'h0001,1'b0, 1'b1,1'b0,16'h0001,1'b0,1'b0,11'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,16'h0002,1'b0, 1'b1,1'b0,16'h0002,1'b0,1'b0,11'd0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,1'b1,16'h0003,1'b0, 1'b1,1'b0,16'h0003,1'b0,1'b0,11'd0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1,16'h0004,1'b0, 1'b1,1'b0,16'h0004,1'b0,1'b0,11'd0,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h0004,1'b1,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h0004,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,16'h00A1,1'b0, 1'b0,1'b1,16'h00A1,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,16'h00A2,1'b0, 1'b0,1'b0,16'h00A1,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b1,1'b1,16'h00A3,1'b0, 1'b0,1'b1,16'h00A3,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b1,16'h00A4,1'b0, 1'b0,1'b1,16'h00A4,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,16'h00A5,1'b0, 1'b0,1'b1,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h00A5,1'b1,1'b1,11'd4,1'b0,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b1,16'h00FF,1'b0, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[14] = '{1'b0,1'b1,1'b1,16'h00FE,1'b0, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b0,1'b1,1'b0};
    tbl[19] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b1,1'b1,1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b1,1'b1,1'b0};
    tbl[21] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b1,1'b1,1'b0};
    tbl[22] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b1,11'd4,1'b1,1'b1,1'b0};
    tbl[23] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b0,11'd4,1'b0,1'b1,1'b0};
    tbl[24] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,16'h00A5,1'b0,1'b0,11'd4,1'b0,1'b1,1'b1};
    tbl[25] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,16'h00A5,1'b0,1'b0,11'd4,1'b0,1'b1,1'b1};

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    check("reset_outs", outs(), 64'd0);
    check("reset_line_cnt", {52'd0, bus.o_line_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Two lines ping-pong, third line dropped, then full drain and an illegal read.
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].vs, tbl[i].hr, tbl[i].pv, tbl[i].pd, tbl[i].rd);
      tick();
      check($sformatf("vec%0d", i), outs(),
            {30'd0, tbl[i].wr1, tbl[i].wr2, tbl[i].wd, tbl[i].done, tbl[i].rdy,
             tbl[i].len, tbl[i].ch, tbl[i].ovf, tbl[i].err});
    end

    // Reset in the middle of a line clears outputs without waiting for a clock.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h0010 + 16'(i), 1'b0);
      tick();
    end
    check("pre_reset_wr1", {63'd0, bus.o_fifo1_wr_en}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", outs(), 64'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Fresh frame: 8-pixel line lands in fifo1 with one-cycle lag.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'(i), 1'b0);
      tick();
      check($sformatf("line8_px%0d", i), {46'd0, bus.o_fifo1_wr_en, bus.o_fifo2_wr_en, bus.o_wr_data},
            {46'd0, 1'b1, 1'b0, 16'(i)});
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("line8_commit", {48'd0, bus.o_line_done, bus.o_line_ready, bus.o_line_len, bus.o_fifo_choose, bus.o_overflow},
          {48'd0, 1'b1, 1'b1, 11'd8, 1'b0, 1'b0});
    check("line8_cnt", {52'd0, bus.o_line_cnt}, {52'd0, exp_cnt});

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("drain8", {61'd0, bus.o_fifo_choose, bus.o_line_ready, bus.o_rd_err}, {61'd0, 1'b1, 1'b0, 1'b0});

    // Over-long line goes to fifo2 and is truncated at the buffer depth.
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 1027; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'(i), 1'b0);
      tick();
      n1 += int'(bus.o_fifo1_wr_en);
      n2 += int'(bus.o_fifo2_wr_en);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("trunc_strobes2", 64'(n2), 64'd1024);
    check("trunc_strobes1", 64'(n1), 64'd0);
    check("trunc_commit", {48'd0, bus.o_line_done, bus.o_line_ready, bus.o_line_len, bus.o_fifo_choose, bus.o_overflow},
          {48'd0, 1'b1, 1'b1, 11'd1024, 1'b1, 1'b1});

    // vsync rise after 5 pixels discards the partial line in fifo1 and keeps fifo2.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h0030 + 16'(i), 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0035, 1'b0);
    tick();
    check("abort_no_write", {62'd0, bus.o_fifo1_wr_en, bus.o_line_done}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("abort_keep", {49'd0, bus.o_line_done, bus.o_line_ready, bus.o_line_len, bus.o_fifo_choose},
          {49'd0, 1'b0, 1'b1, 11'd1024, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    n1 = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h0055 + 16'(i), 1'b0);
      tick();
      n1 += int'(bus.o_fifo1_wr_en);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    check("after_abort_wr1", 64'(n1), 64'd2);
    check("after_abort_done", {63'd0, bus.o_line_done}, 64'd1);
    check("after_abort_cnt", {52'd0, bus.o_line_cnt}, {52'd0, exp_cnt});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpong_line_ctrl.md
Name: pingpong_line_ctrl

Overview:
- Write-side scheduler for the two 16-bit line FIFOs read by the AXI register slave.
- Steers camera pixels (i_href/i_vsync framing) alternately into fifo1/fifo2, one video line per buffer, and tracks per-buffer state (EMPTY/FILLING/FULL/DRAINING).
- Drives the read-side FIFO select and "line ready" to the slave, counts down slave reads, and frees each buffer when its line is drained.

Parameters:
DATA_WIDTH, 16, pixel/FIFO data width
FIFO_DEPTH, 1024, max pixels per buffer; extra pixels in a line are dropped
CNT_WIDTH, 11, width of pixel/length counters; must hold FIFO_DEPTH

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_vsync  input  1  frame sync, high = vertical blanking, synchronous to clk
i_href  input  1  line valid, synchronous to clk
i_pixel_valid  input  1  pixel strobe, qualified by i_href
i_pixel_data  input  DATA_WIDTH  pixel value
o_fifo1_wr_en  output  1  write strobe, fifo1
o_fifo2_wr_en  output  1  write strobe, fifo2
o_wr_data  output  DATA_WIDTH  registered pixel data to both FIFOs
i_fifo_rd_en  input  1  read strobe from the AXI slave
o_fifo_choose  output  1  0 = fifo1, 1 = fifo2 (read side)
o_line_ready  output  1  selected read buffer is FULL or DRAINING
o_line_len  output  CNT_WIDTH  pixel count of the selected read buffer
o_line_done  output  1  one-cycle pulse when a line is committed FULL
o_overflow  output  1  sticky: line dropped or pixels truncated
o_rd_err  output  1  sticky: i_fifo_rd_en with no readable line
o_line_cnt  output  12  lines committed this frame (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0, including o_fifo_choose.
  - Both buffers EMPTY; write select = fifo1; write FSM = W_IDLE.
- Edge detection: i_href and i_vsync are registered once (href_d, vsync_d).
  - rise = x & ~x_d; fall = ~x & x_d.
- Write FSM states: W_IDLE, W_WAIT, W_FILL, W_DROP.
  - W_IDLE: on vsync fall -> W_WAIT.
  - W_WAIT: on href rise with vsync low:
    - Target buffer EMPTY -> W_FILL; buffer := FILLING; pixel count := 0.
    - Otherwise -> W_DROP; o_overflow := 1.
  - W_FILL: each cycle with i_href & i_pixel_valid & count < FIFO_DEPTH:
    - Write strobe of the target buffer = 1 on the next cycle; o_wr_data = pixel. Latency is exactly 1 cycle.
    - count += 1.
  - W_FILL, pixel arriving at count == FIFO_DEPTH: pixel is dropped; o_overflow := 1.
  - W_FILL, href fall with count > 0:
    - Buffer := FULL; its length := count.
    - o_line_done pulses on the next cycle.
    - Write select toggles. -> W_WAIT.
  - W_FILL, href fall with count == 0: buffer := EMPTY; no pulse; no toggle. -> W_WAIT.
  - W_DROP: on href fall -> W_WAIT.
  - Any state, vsync rise:
    - -> W_IDLE.
    - A FILLING buffer is returned to EMPTY (partial line discarded); write select is unchanged.
    - FULL and DRAINING buffers are kept.
- Read side (o_fifo_choose = read select):
  - o_line_ready = read buffer in {FULL, DRAINING}.
  - o_line_len = stored length of the read buffer.
  - i_fifo_rd_en while ready:
    - FULL -> DRAINING.
    - Remaining count -= 1.
    - When remaining reaches 0 on a read: buffer := EMPTY and the read select toggles on the next cycle.
  - i_fifo_rd_en while not ready: ignored; o_rd_err := 1.
- Simultaneous events:
  - A commit on one buffer and a drain-complete on the other in the same cycle both take effect.
  - A buffer freed by a read in the same cycle as an href rise targeting it counts as not EMPTY: the line is dropped.
- Sticky flags clear only on reset.
- Reset mid-line:
  - Write strobes are deasserted asynchronously.
  - All buffer state is lost; the external FIFOs must be reset alongside.

Optional Feature:
- Macro: PINGPONG_LINE_CNT_EN.
- Defined:
  - o_line_cnt increments (saturating at 4095) on each o_line_done.
  - It clears on vsync rise.
- Undefined:
  - o_line_cnt tied to 0.
  - The counter logic is not present.

Test Plan:
- vsync fall; href high 8 cycles with valid each cycle, data 0x0001..0x0008 -> o_fifo1_wr_en high 8 cycles (1-cycle lag), o_wr_data matches in order; o_line_done pulse; o_line_ready=1, o_line_len=8, o_fifo_choose=0.
- Two 4-pixel lines, no reads -> line 2 goes to fifo2. Third href rise -> o_overflow=1, fifo write strobes stay 0 for that line.
- After the two lines above, 4 i_fifo_rd_en pulses -> fifo1 EMPTY, o_fifo_choose=1, o_line_len=4. Then 4 more reads -> o_line_ready=0. 5th read -> o_rd_err=1.
- Line of FIFO_DEPTH+3 pixels -> exactly FIFO_DEPTH write strobes; o_line_len=1024; o_overflow=1.
- vsync rise mid-line after 5 pixels -> buffer EMPTY, no o_line_done, write select unchanged. With PINGPONG_LINE_CNT_EN: 3 lines -> o_line_cnt=3, then 0 after vsync rise.
- rst_n low mid-line -> all outputs 0 immediately; the next frame starts on fifo1.
